data_unpacker: RTL and testbench

Inverse of the trace data packer. Accepts full N-wide packed vectors and re-emits them as consecutive chunks of N, M or 1 values per chain, using a per-chain firmware mode. Sits on the readback/replay side of the trace buffer and feeds downstream consumers that expect the original block granularity. Uses a valid/ready handshake on both sides and is configured over the same configId/configData byte bus as the other instrumentation blocks.

---
 rtl/data_unpacker_pkg.sv | 31 +++
 rtl/data_unpacker_if.sv | 40 ++++
 rtl/unpack_lane_select.sv | 34 +++
 rtl/data_unpacker.sv | 161 ++++++++++++++++
 tb/tb_data_unpacker.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_unpacker_pkg.sv
// -----------------------------------------------------------------------------
// data_unpacker_pkg
// Shared definitions for the trace data unpacker: per-chain firmware mode
// encodings, the controller state type and a helper that maps a mode byte to
// the chunk width it selects.
// -----------------------------------------------------------------------------
package data_unpacker_pkg;

  // Firmware mode byte values. Any other value means "accept and drop".
  localparam logic [7:0] MODE_N = 8'd0;  // emit the whole vector at once
  localparam logic [7:0] MODE_M = 8'd1;  // emit M words per chunk
  localparam logic [7:0] MODE_1 = 8'd2;  // emit one word per chunk

  typedef enum logic {
    IDLE,  // nothing held
    EMIT   // held vector being drained chunk by chunk
  } state_e;

  // Chunk width selected by a mode byte; 0 marks a dropped vector.
  function automatic int unsigned chunk_width(input logic [7:0] mode,
                                              input int unsigned n,
                                              input int unsigned m);
    case (mode)
      MODE_N:  return n;
      MODE_M:  return m;
      MODE_1:  return 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/data_unpacker_if.sv
// -----------------------------------------------------------------------------
// data_unpacker_if
// Handshake bundle of the unpacker: the packed-vector input stream and the
// chunk output stream.
//   valid_in / ready_in / chainId_in / vector_in        : packed vector in
//   valid_out / ready_out / vector_out / last_out /
//   chainId_out                                        : chunk out
// Modports:
//   slave  - the unpacker itself
//   master - the environment (upstream producer + downstream consumer)
// -----------------------------------------------------------------------------
interface data_unpacker_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4
);
  localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;

  logic                           valid_in;
  logic                           ready_in;
  logic [CW-1:0]                  chainId_in;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_in;

  logic                           valid_out;
  logic                           ready_out;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_out;
  logic                           last_out;
  logic [CW-1:0]                  chainId_out;

  modport slave (
    input  valid_in, chainId_in, vector_in, ready_out,
    output ready_in, valid_out, vector_out, last_out, chainId_out
  );

  modport master (
    output valid_in, chainId_in, vector_in, ready_out,
    input  ready_in, valid_out, vector_out, last_out, chainId_out
  );

endinterface

// File: rtl/unpack_lane_select.sv
// -----------------------------------------------------------------------------
// unpack_lane_select
// Combinational chunk extractor: chunk_o[i] = vec_i[ptr_i + i] for i < w_i,
// all other lanes 0.
//   vec_i   : held packed vector, word 0 oldest
//   ptr_i   : first word of the chunk
//   w_i     : chunk width in words
//   chunk_o : chunk in lanes [0 .. w_i-1]
// -----------------------------------------------------------------------------
module unpack_lane_select #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int PW         = 4
) (
  input  logic [N-1:0][DATA_WIDTH-1:0] vec_i,
  input  logic [PW-1:0]                ptr_i,
  input  logic [PW-1:0]                w_i,
  output logic [N-1:0][DATA_WIDTH-1:0] chunk_o
);

  logic [N-1:0][DATA_WIDTH-1:0] shifted;

  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned, which would infer a latch.
    chunk_o = '0;
    // Word ptr moves down to lane 0; words past the top fill with zeros.
    shifted = vec_i >> (int'(ptr_i) * DATA_WIDTH);
    for (int i = 0; i < N; i++) begin
      if (PW'(i) < w_i) chunk_o[i] = shifted[i];
    end
  end

endmodule

// File: rtl/data_unpacker.sv
// -----------------------------------------------------------------------------
// data_unpacker
// Re-emits packed N-word vectors as consecutive chunks of N, M or 1 words,
// selected per chain by a firmware byte written over the config byte bus.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   tracing             : 1 = normal operation, 0 = reconfiguration window
//   configId/configData : config byte bus
//   bus (slave)         : vector input stream and chunk output stream
// Outputs are registered; the first chunk is valid the cycle after accept.
// A new vector can be accepted in the same cycle the final chunk of the
// previous one is taken, so streams of vectors flow without bubbles.
// -----------------------------------------------------------------------------
module data_unpacker
  import data_unpacker_pkg::*;
#(
  parameter int                        N                  = 8,
  parameter int                        M                  = 2,
  parameter int                        DATA_WIDTH         = 32,
  parameter int                        MAX_CHAINS         = 4,
  parameter logic [7:0]                PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tracing,
  input  logic [7:0]       configId,
  input  logic [7:0]       configData,
  data_unpacker_if.slave   bus
);

  localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int PW = $clog2(N + 1);
  localparam int BW = $clog2(MAX_CHAINS + 1);
  localparam logic [BW-1:0] CNT_MAX = BW'(MAX_CHAINS);

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  if (M < 2 || M > N || (N % M) != 0) begin : g_bad_cfg
    $error("data_unpacker: N must be a multiple of M with 1 < M <= N");
  end

  // Controller state
  state_e                 state_q;
  vec_t                   held_q;
  logic [PW-1:0]          w_q;
  logic [PW-1:0]          ptr_q;     // first word of the chunk on the outputs
  logic                   valid_q;
  logic                   last_q;
  vec_t                   vec_q;
  logic [CW-1:0]          chain_q;

  // Configuration state
  logic [MAX_CHAINS-1:0][7:0] firmware_q;
  logic [BW-1:0]              byte_cnt_q;

  // Handshake decode
  logic          ready_in;
  logic          accept;
  logic          load;
  logic          advance;
  logic          finish;
  logic [PW-1:0] w_new;
  logic [PW-1:0] next_ptr;

  // Next chunk source: either the incoming vector or the held one
  vec_t          sel_vec;
  logic [PW-1:0] sel_ptr;
  logic [PW-1:0] sel_w;
  logic [PW:0]   sel_end;
  logic          last_d;
  vec_t          chunk_d;

  assign w_new    = PW'(chunk_width(firmware_q[bus.chainId_in], N, M));
  assign ready_in = tracing && (state_q == IDLE || (last_q && bus.ready_out));
  assign accept   = bus.valid_in && ready_in;
  assign load     = accept && (w_new != '0);
  assign advance  = (state_q == EMIT) && bus.ready_out && !last_q;
  assign finish   = (state_q == EMIT) && bus.ready_out && last_q;
  assign next_ptr = ptr_q + w_q;

  assign sel_vec  = load ? bus.vector_in : held_q;
  assign sel_ptr  = load ? '0 : next_ptr;
  assign sel_w    = load ? w_new : w_q;
  assign sel_end  = {1'b0, sel_ptr} + {1'b0, sel_w};
  assign last_d   = (sel_end == (PW+1)'(N));

  unpack_lane_select #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH),
    .PW         (PW)
  ) u_lane_select (
    .vec_i   (sel_vec),
    .ptr_i   (sel_ptr),
    .w_i     (sel_w),
    .chunk_o (chunk_d)
  );

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      held_q  <= '0;
      w_q     <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      vec_q   <= '0;
      chain_q <= '0;
    end else if (load) begin
      // Covers both a fresh accept from IDLE and pass-through after last.
      state_q <= EMIT;
      held_q  <= bus.vector_in;
      w_q     <= w_new;
      ptr_q   <= '0;
      chain_q <= bus.chainId_in;
      valid_q <= 1'b1;
      vec_q   <= chunk_d;
      last_q  <= last_d;
    end else if (advance) begin
      ptr_q   <= next_ptr;
      vec_q   <= chunk_d;
      last_q  <= last_d;
    end else if (finish) begin
      // Final chunk taken with no new (or only a dropped) vector behind it.
      state_q <= IDLE;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      vec_q   <= '0;
      last_q  <= 1'b0;
    end
  end

  // Firmware bytes arrive in chain order while addressed; any foreign id
  // rewinds the byte counter so the next burst starts at chain 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the firmware table is a small register file, not RAM, so it
      // takes its reset value directly and needs no load sequence.
      firmware_q <= INITIAL_FIRMWARE;
      byte_cnt_q <= '0;
    end else if (!tracing) begin
      if (configId == PERSONAL_CONFIG_ID) begin
        if (byte_cnt_q < CNT_MAX) begin
          firmware_q[byte_cnt_q[CW-1:0]] <= configData;
          byte_cnt_q                     <= byte_cnt_q + BW'(1);
        end
      end else begin
        byte_cnt_q <= '0;
      end
    end
  end

  assign bus.ready_in    = ready_in;
  assign bus.valid_out   = valid_q;
  assign bus.vector_out  = vec_q;
  assign bus.last_out    = last_q;
  assign bus.chainId_out = chain_q;

endmodule

// File: tb/tb_data_unpacker.sv
// -----------------------------------------------------------------------------
// tb_data_unpacker
// Self-checking bench for data_unpacker (N=8, M=2, 32-bit words, 4 chains).
// A queue-based reference model expands every accepted vector into its list
// of expected chunks; each cycle the outputs are compared with the queue head.
// Directed table entries and hand-written sequences add fixed expectations.
// -----------------------------------------------------------------------------
module tb_data_unpacker;

  localparam int N  = 8;
  localparam int M  = 2;
  localparam int DW = 32;
  localparam int MC = 4;

  typedef logic [N-1:0][DW-1:0] vec_t;

  typedef struct {
    vec_t       vec;
    logic       last;
    logic [1:0] chain;
  } chunk_t;

  typedef struct {
    logic [1:0]  chain;
    logic [31:0] base;
    int          exp_chunks;
    logic [31:0] exp_lane0;
    logic [31:0] exp_lane1;
    logic [31:0] exp_lane7;
  } vec_rec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tracing;
  logic [7:0] configId;
  logic [7:0] configData;

  data_unpacker_if #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC)) bus ();

  data_unpacker #(
    .N                  (N),
    .M                  (M),
    .DATA_WIDTH         (DW),
    .MAX_CHAINS         (MC),
    .PERSONAL_CONFIG_ID (8'd0),
    .INITIAL_FIRMWARE   ('0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tracing    (tracing),
    .configId   (configId),
    .configData (configData),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  chunk_t     exp_q[$];
  logic [7:0] fw_m[MC];
  int         cnt_m;
  bit         exp_ready;
  bit         accepted;
  int         cyc;
  int         hs_count;
  int         last_hs_cyc;
  bit         got_first;
  int         first_cyc;
  vec_t       first_vec;

  task automatic check(input string name, input logic [N*DW-1:0] act,
                       input logic [N*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t ramp(input logic [31:0] base);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = base + 32'(i);
    return v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int c = 0; c < MC; c++) fw_m[c] = 8'd0;
    cnt_m = 0;
  endtask

  // Expand an accepted vector into its chunks according to the chain mode.
  task automatic model_push(input logic [1:0] ch, input vec_t v);
    int     w;
    chunk_t c;
    case (fw_m[ch])
      8'd0:    w = N;
      8'd1:    w = M;
      8'd2:    w = 1;
      default: w = 0;
    endcase
    if (w == 0) return;
    for (int k = 0; k < N / w; k++) begin
      c.vec = '0;
      for (int i = 0; i < w; i++) c.vec[i] = v[k * w + i];
      c.last  = (k == N / w - 1);
      c.chain = ch;
      exp_q.push_back(c);
    end
  endtask

  task automatic compare_outputs();
    bit   evld;
    vec_t ev;
    logic el;
    evld = (exp_q.size() > 0);
    ev   = evld ? exp_q[0].vec : '0;
    el   = evld ? exp_q[0].last : 1'b0;
    exp_ready = tracing && (exp_q.size() == 0 ||
                            (exp_q.size() == 1 && bus.ready_out));
    check("valid_out", bus.valid_out, evld);
    check("vector_out", bus.vector_out, ev);
    check("last_out", bus.last_out, el);
    check("ready_in", bus.ready_in, exp_ready);
    if (evld) check("chainId_out", bus.chainId_out, exp_q[0].chain);
    if (!got_first && bus.valid_out === 1'b1) begin
      got_first = 1'b1;
      first_cyc = cyc;
      first_vec = bus.vector_out;
    end
  endtask

  task automatic model_update();
    accepted = 1'b0;
    if (!rst_n) return;
    if (exp_q.size() > 0 && bus.ready_out) begin
      hs_count++;
      last_hs_cyc = cyc;
      void'(exp_q.pop_front());
    end
    if (bus.valid_in && exp_ready) begin
      accepted = 1'b1;
      model_push(bus.chainId_in, bus.vector_in);
    end
    if (!tracing) begin
      if (configId == 8'd0) begin
        if (cnt_m < MC) begin
          fw_m[cnt_m] = configData;
          cnt_m++;
        end
      end else begin
        cnt_m = 0;
      end
    end
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic tick();
    #1;
    compare_outputs();
    model_update();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] id, input logic [7:0] data);
    tracing    = 1'b0;
    configId   = id;
    configData = data;
    tick();
    tracing    = 1'b1;
    configId   = 8'hFF;
  endtask

  task automatic send(input logic [1:0] ch, input logic [31:0] base,
                      output int acc_cyc);
    int guard;
    bus.valid_in   = 1'b1;
    bus.chainId_in = ch;
    bus.vector_in  = ramp(base);
    guard = 0;
    acc_cyc = -1;
    do begin
      acc_cyc = cyc;
      tick();
      guard++;
    end while (!accepted && guard < 40);
    if (!accepted) check("send timeout", 0, 1);
    bus.valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain timeout", exp_q.size(), 0);
    tick();
  endtask

  task automatic clear_stats();
    hs_count  = 0;
    got_first = 1'b0;
    first_vec = '0;
    first_cyc = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_rec_t table_v[5];
  int       acc;
  int       acc_a;

  initial begin
    // Directed table; firmware is {0,1,2,3} for chains 0..3 when it runs.
    table_v[0] = '{2'd0, 32'd0,     1, 32'd0,     32'd1,  32'd7};
    table_v[1] = '{2'd1, 32'd10,    4, 32'd10,    32'd11, 32'd0};
    table_v[2] = '{2'd2, 32'hA0,    8, 32'hA0,    32'd0,  32'd0};
    table_v[3] = '{2'd3, 32'h30,    0, 32'd0,     32'd0,  32'd0};
    table_v[4] = '{2'd0, 32'd100,   1, 32'd100,   32'd101, 32'd107};

    cyc            = 0;
    rst_n          = 1'b0;
    tracing        = 1'b1;
    configId       = 8'hFF;
    configData     = 8'd0;
    bus.valid_in   = 1'b0;
    bus.chainId_in = '0;
    bus.vector_in  = '0;
    bus.ready_out  = 1'b1;
    model_reset();
    clear_stats();
    @(posedge clk);
    #1;
    check("reset chainId_out", bus.chainId_out, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Firmware {0,1,2,3}
    cfg(8'h55, 8'd0);
    cfg(8'd0, 8'd0);
    cfg(8'd0, 8'd1);
    cfg(8'd0, 8'd2);
    cfg(8'd0, 8'd3);
    tick();

    foreach (table_v[t]) begin
      clear_stats();
      send(table_v[t].chain, table_v[t].base, acc);
      drain();
      check("table chunks", hs_count, table_v[t].exp_chunks);
      check("table lane0", first_vec[0], table_v[t].exp_lane0);
      check("table lane1", first_vec[1], table_v[t].exp_lane1);
      check("table lane7", first_vec[7], table_v[t].exp_lane7);
      if (table_v[t].exp_chunks > 0) check("table latency", first_cyc - acc, 1);
    end

    // Back-to-back single-word chunks: 16 handshakes in 16 cycles.
    clear_stats();
    send(2'd2, 32'hA0, acc_a);
    send(2'd2, 32'hB0, acc);
    drain();
    check("b2b chunks", hs_count, 16);
    check("b2b no bubble", last_hs_cyc - first_cyc + 1, 16);
    check("b2b second accept", acc - acc_a, 8);

    // Stall during mode-1 emit: ready_out 1,0,0,1.
    clear_stats();
    send(2'd1, 32'h40, acc);
    bus.ready_out = 1'b1;
    tick();
    bus.ready_out = 1'b0;
    check("stall lane0 a", bus.vector_out[0], 32'h42);
    tick();
    check("stall lane0 b", bus.vector_out[0], 32'h42);
    check("stall lane1 b", bus.vector_out[1], 32'h43);
    tick();
    bus.ready_out = 1'b1;
    tick();
    drain();
    check("stall chunks", hs_count, 4);

    // Firmware {3,1,2,0}: chain 0 now drops.
    cfg(8'h55, 8'd0);
    cfg(8'd0, 8'd3);
    cfg(8'd0, 8'd1);
    cfg(8'd0, 8'd2);
    cfg(8'd0, 8'd0);
    cfg(8'd0, 8'd7);   // counter saturated: ignored
    clear_stats();
    send(2'd0, 32'h70, acc);
    for (int k = 0; k < 3; k++) begin
      check("drop valid_out", bus.valid_out, 0);
      tick();
    end
    check("drop chunks", hs_count, 0);

    // Reset while emitting at ptr=4.
    send(2'd1, 32'h80, acc);
    tick();
    tick();
    check("pre-reset lane0", bus.vector_out[0], 32'h84);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset valid_out", bus.valid_out, 0);
    check("reset ready_in", bus.ready_in, 1);
    tick();
    rst_n = 1'b1;
    tick();
    clear_stats();
    send(2'd0, 32'h90, acc);
    drain();
    check("fw after reset", hs_count, 1);
    check("fw after reset lane7", first_vec[7], 32'h97);

    // Randomised traffic against the model.
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int b = 0; b < 5; b++) begin
          bus.valid_in  = $urandom_range(0, 1);
          bus.ready_out = $urandom_range(0, 3) != 0;
          cfg(($urandom_range(0, 3) == 0) ? 8'd9 : 8'd0,
              ($urandom_range(0, 4) == 4) ? 8'h80 : 8'($urandom_range(0, 2)));
        end
      end else begin
        bus.valid_in   = $urandom_range(0, 9) < 6;
        bus.chainId_in = 2'($urandom_range(0, 3));
        for (int i = 0; i < N; i++) bus.vector_in[i] = $urandom;
        bus.ready_out  = $urandom_range(0, 9) < 7;
        tick();
      end
    end
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
